// File: rtl/easy_fifo_axis_downsizer.sv
// -----------------------------------------------------------------------------
// easy_fifo_axis_downsizer
//
// AXI-Stream width down-converter for the read side of easy_fifo_axis_async,
// running in the FIFO's m_axis_clk domain. Each accepted wide word is replayed
// as DWIDTH_IN/DWIDTH_OUT narrow beats, least-significant slice first. When the
// last slice of a word leaves on the same edge a new word arrives, the new word
// loads directly, so a steady source and sink see one beat per cycle.
//
// Optional feature macro: EASY_FIFO_DOWNSIZER_TLAST_EN
//   defined   -> s_axis_tlast / m_axis_tlast exist; tlast marks the final
//                slice of a word tagged last.
//   undefined -> no tlast ports and no tlast register.
//
// Parameters:
//   DWIDTH_IN   wide input word width (integer multiple of DWIDTH_OUT)
//   DWIDTH_OUT  narrow output beat width (>= 1)
//
// Ports:
//   clk            single clock (the FIFO's m_axis_clk)
//   rst_n          asynchronous active-low reset
//   s_axis_tdata   wide word from the FIFO
//   s_axis_tvalid  wide word valid
//   s_axis_tready  wide word accepted when high together with s_axis_tvalid
//   s_axis_tlast   end-of-packet on the wide word (macro only)
//   m_axis_tdata   narrow beat
//   m_axis_tvalid  narrow beat valid
//   m_axis_tready  downstream ready
//   m_axis_tlast   end-of-packet on the narrow beat (macro only)
// -----------------------------------------------------------------------------
module easy_fifo_axis_downsizer #(
   parameter int DWIDTH_IN  = 32,
   parameter int DWIDTH_OUT = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DWIDTH_IN-1:0]  s_axis_tdata,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
`ifdef EASY_FIFO_DOWNSIZER_TLAST_EN
   input  logic                  s_axis_tlast,
   output logic                  m_axis_tlast,
`endif
   output logic [DWIDTH_OUT-1:0] m_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready
);

   localparam int RATIO  = DWIDTH_IN / DWIDTH_OUT;
   localparam int CWIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;

   generate
      if (DWIDTH_OUT < 1 || (DWIDTH_IN % DWIDTH_OUT) != 0) begin : g_bad_width
         $error("easy_fifo_axis_downsizer: DWIDTH_IN must be a multiple of DWIDTH_OUT");
      end
   endgenerate

   logic [DWIDTH_IN-1:0] hold;
   logic                 full;
   logic [CWIDTH-1:0]    cnt;
   logic                 last_beat;
   logic                 in_acc;
   logic                 out_acc;

   assign last_beat = (cnt == CWIDTH'(RATIO - 1));

   // rst_n is folded in so the upstream FIFO sees "not ready" for the whole
   // time reset is asserted, independent of any clock edge.
   assign s_axis_tready = rst_n & (~full | (m_axis_tready & last_beat));
   assign m_axis_tvalid = full;

   assign in_acc  = s_axis_tvalid & s_axis_tready;
   assign out_acc = full & m_axis_tready;

   // An input accept while full can only happen on the last beat's hand-off,
   // so giving it priority covers both the idle load and the no-bubble reload.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: hold is a data register, but it is reset anyway because
         // m_axis_tdata must read zero while reset is asserted.
         hold <= '0;
         full <= 1'b0;
         cnt  <= '0;
      end else if (in_acc) begin
         // NOTE: non-blocking assignments keep every register sampling the
         // pre-edge values, so hold/full/cnt update as one consistent state.
         hold <= s_axis_tdata;
         full <= 1'b1;
         cnt  <= '0;
      end else if (out_acc) begin
         if (last_beat) begin
            full <= 1'b0;
            cnt  <= '0;
         end else begin
            cnt  <= cnt + CWIDTH'(1);
         end
      end
   end

   // Slice mux: driven only from registers, no path from s_axis_*.
   generate
      if (RATIO == 1) begin : g_passthrough
         assign m_axis_tdata = hold;
      end else begin : g_slice
         logic [RATIO-1:0][DWIDTH_OUT-1:0] slices;
         assign slices       = hold;
         assign m_axis_tdata = slices[cnt];
      end
   endgenerate

`ifdef EASY_FIFO_DOWNSIZER_TLAST_EN
   logic last_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q <= 1'b0;
      end else if (in_acc) begin
         last_q <= s_axis_tlast;
      end
   end

   assign m_axis_tlast = full & last_q & last_beat;
`endif

endmodule

// File: tb/tb_easy_fifo_axis_downsizer.sv
// -----------------------------------------------------------------------------
// tb_easy_fifo_axis_downsizer
//
// Self-checking bench for easy_fifo_axis_downsizer. One instance at 32->8 is
// driven from a vector table, hand-written reset/backpressure sequences and a
// randomized run against a queue-based reference model; a second instance at
// 16->16 exercises the one-entry pipeline case. Works with or without
// EASY_FIFO_DOWNSIZER_TLAST_EN.
// -----------------------------------------------------------------------------
module tb_easy_fifo_axis_downsizer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n;

   // 32 -> 8 instance
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        s_last;
   logic [7:0]  m_data;
   logic        m_valid;
   logic        m_ready;
   logic        m_last;

   // 16 -> 16 instance
   logic [15:0] w_s_data;
   logic        w_s_valid;
   logic        w_s_ready;
   logic        w_s_last;
   logic [15:0] w_m_data;
   logic        w_m_valid;
   logic        w_m_ready;
   logic        w_m_last;

   easy_fifo_axis_downsizer #(.DWIDTH_IN(32), .DWIDTH_OUT(8)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (s_data),
      .s_axis_tvalid (s_valid),
      .s_axis_tready (s_ready),
`ifdef EASY_FIFO_DOWNSIZER_TLAST_EN
      .s_axis_tlast  (s_last),
      .m_axis_tlast  (m_last),
`endif
      .m_axis_tdata  (m_data),
      .m_axis_tvalid (m_valid),
      .m_axis_tready (m_ready)
   );

   easy_fifo_axis_downsizer #(.DWIDTH_IN(16), .DWIDTH_OUT(16)) dut1 (
      .clk           (clk),
      .rst_n         (rst_n),
      .s_axis_tdata  (w_s_data),
      .s_axis_tvalid (w_s_valid),
      .s_axis_tready (w_s_ready),
`ifdef EASY_FIFO_DOWNSIZER_TLAST_EN
      .s_axis_tlast  (w_s_last),
      .m_axis_tlast  (w_m_last),
`endif
      .m_axis_tdata  (w_m_data),
      .m_axis_tvalid (w_m_valid),
      .m_axis_tready (w_m_ready)
   );

`ifndef EASY_FIFO_DOWNSIZER_TLAST_EN
   assign m_last   = 1'b0;
   assign w_m_last = 1'b0;
`endif

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One table row = inputs held for one cycle and the outputs expected
   // during that cycle (before the closing edge).
   typedef struct {
      logic        sv;
      logic [31:0] sd;
      logic        sl;
      logic        mr;
      logic        ev;
      logic [7:0]  ed;
      logic        esr;
      logic        el;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic sv, input logic [31:0] sd, input logic sl, input logic mr,
                      input logic ev, input logic [7:0] ed, input logic esr, input logic el);
      vec_t v;
      v.sv = sv; v.sd = sd; v.sl = sl; v.mr = mr;
      v.ev = ev; v.ed = ed; v.esr = esr; v.el = el;
      vecs.push_back(v);
   endtask

   // Reference model beat: one narrow slice plus its tlast flag.
   typedef struct {
      logic [15:0] d;
      logic        l;
   } beat_t;

   initial begin
      beat_t q[$];
      logic [15:0] got[$];
      int next_item;

      rst_n = 1'b0;
      s_valid = 1'b0; s_data = '0; s_last = 1'b0; m_ready = 1'b0;
      w_s_valid = 1'b0; w_s_data = '0; w_s_last = 1'b0; w_m_ready = 1'b0;

      // ---------------- reset state ----------------
      #2;
      check("reset_m_valid", 32'(m_valid), 32'h0);
      check("reset_m_data", 32'(m_data), 32'h0);
      check("reset_s_ready", 32'(s_ready), 32'h0);
      check("reset_m_last", 32'(m_last), 32'h0);
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("release_s_ready", 32'(s_ready), 32'h1);
      check("release_w_s_ready", 32'(w_s_ready), 32'h1);

      // ---------------- vector table ----------------
      // single word, sink always ready
      add(1, 32'h44332211, 0, 1, 0, 8'h00, 1, 0);
      add(0, 32'h0,        0, 1, 1, 8'h11, 0, 0);
      add(0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
      add(0, 32'h0,        0, 1, 1, 8'h33, 0, 0);
      add(0, 32'h0,        0, 1, 1, 8'h44, 1, 0);
      add(0, 32'h0,        0, 1, 0, 8'h00, 1, 0);
      // back-to-back words, no gap
      add(1, 32'h44332211, 0, 1, 0, 8'h00, 1, 0);
      add(1, 32'h88776655, 0, 1, 1, 8'h11, 0, 0);
      add(1, 32'h88776655, 0, 1, 1, 8'h22, 0, 0);
      add(1, 32'h88776655, 0, 1, 1, 8'h33, 0, 0);
      add(1, 32'h88776655, 0, 1, 1, 8'h44, 1, 0);
      add(0, 32'h0,        0, 1, 1, 8'h55, 0, 0);
      add(0, 32'h0,        0, 1, 1, 8'h66, 0, 0);
      add(0, 32'h0,        0, 1, 1, 8'h77, 0, 0);
      add(0, 32'h0,        0, 1, 1, 8'h88, 1, 0);
      add(0, 32'h0,        0, 1, 0, 8'h00, 1, 0);
      // backpressure while 0x22 is presented
      add(1, 32'h44332211, 0, 1, 0, 8'h00, 1, 0);
      add(0, 32'h0,        0, 1, 1, 8'h11, 0, 0);
      add(0, 32'h0,        0, 0, 1, 8'h22, 0, 0);
      add(0, 32'h0,        0, 0, 1, 8'h22, 0, 0);
      add(0, 32'h0,        0, 0, 1, 8'h22, 0, 0);
      add(0, 32'h0,        0, 1, 1, 8'h22, 0, 0);
      add(0, 32'h0,        0, 1, 1, 8'h33, 0, 0);
      add(0, 32'h0,        0, 1, 1, 8'h44, 1, 0);
      add(0, 32'h0,        0, 1, 0, 8'h00, 1, 0);
      // tlast only on the final slice of the tagged word
      add(1, 32'h04030201, 0, 1, 0, 8'h00, 1, 0);
      add(1, 32'h08070605, 1, 1, 1, 8'h01, 0, 0);
      add(1, 32'h08070605, 1, 1, 1, 8'h02, 0, 0);
      add(1, 32'h08070605, 1, 1, 1, 8'h03, 0, 0);
      add(1, 32'h08070605, 1, 1, 1, 8'h04, 1, 0);
      add(0, 32'h0,        0, 1, 1, 8'h05, 0, 0);
      add(0, 32'h0,        0, 1, 1, 8'h06, 0, 0);
      add(0, 32'h0,        0, 1, 1, 8'h07, 0, 0);
`ifdef EASY_FIFO_DOWNSIZER_TLAST_EN
      add(0, 32'h0,        0, 1, 1, 8'h08, 1, 1);
`else
      add(0, 32'h0,        0, 1, 1, 8'h08, 1, 0);
`endif
      add(0, 32'h0,        0, 1, 0, 8'h00, 1, 0);

      foreach (vecs[i]) begin
         s_valid = vecs[i].sv; s_data = vecs[i].sd; s_last = vecs[i].sl; m_ready = vecs[i].mr;
         @(negedge clk);
         check($sformatf("vec%0d_m_valid", i), 32'(m_valid), 32'(vecs[i].ev));
         check($sformatf("vec%0d_s_ready", i), 32'(s_ready), 32'(vecs[i].esr));
         check($sformatf("vec%0d_m_last", i), 32'(m_last), 32'(vecs[i].el));
         if (vecs[i].ev)
            check($sformatf("vec%0d_m_data", i), 32'(m_data), 32'(vecs[i].ed));
         @(posedge clk); #1;
      end

      // ---------------- reset mid-word ----------------
      s_valid = 1'b1; s_data = 32'h44332211; m_ready = 1'b1;
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(posedge clk); #1;               // 0x22 presented
      @(posedge clk); #1;               // 0x22 accepted, 0x33 presented
      check("midrst_before_data", 32'(m_data), 32'h33);
      rst_n = 1'b0;
      #1;
      check("midrst_m_valid", 32'(m_valid), 32'h0);
      check("midrst_s_ready", 32'(s_ready), 32'h0);
      check("midrst_m_data", 32'(m_data), 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      check("midrst_release_s_ready", 32'(s_ready), 32'h1);
      s_valid = 1'b1; s_data = 32'hDDCCBBAA;
      @(posedge clk); #1;
      s_valid = 1'b0;
      @(negedge clk);
      check("midrst_first_valid", 32'(m_valid), 32'h1);
      check("midrst_first_data", 32'(m_data), 32'hAA);
      @(posedge clk); #1;
      @(negedge clk);
      check("midrst_second_data", 32'(m_data), 32'hBB);
      repeat (3) @(posedge clk);
      #1;
      check("midrst_drained", 32'(m_valid), 32'h0);

      // ---------------- randomized run vs. queue model ----------------
      q.delete();
      for (int cyc = 0; cyc < 400; cyc++) begin
         logic exp_v, exp_sr, in_acc, out_acc;
         s_valid = ($urandom_range(0, 3) != 0);
         s_data  = $urandom;
         s_last  = $urandom_range(0, 1) == 1;
         m_ready = ($urandom_range(0, 3) != 0);
         exp_v  = (q.size() != 0);
         exp_sr = (q.size() == 0) || (m_ready && q.size() == 1);
         @(negedge clk);
         check("rnd_m_valid", 32'(m_valid), 32'(exp_v));
         check("rnd_s_ready", 32'(s_ready), 32'(exp_sr));
         if (exp_v) begin
            check("rnd_m_data", 32'(m_data), 32'(q[0].d));
`ifdef EASY_FIFO_DOWNSIZER_TLAST_EN
            check("rnd_m_last", 32'(m_last), 32'(q[0].l));
`endif
         end
         in_acc  = s_valid && exp_sr;
         out_acc = exp_v && m_ready;
         @(posedge clk); #1;
         if (out_acc) void'(q.pop_front());
         if (in_acc) begin
            for (int k = 0; k < 4; k++) begin
               beat_t b;
               b.d = 16'(s_data[k*8 +: 8]);
               b.l = s_last && (k == 3);
               q.push_back(b);
            end
         end
      end
      s_valid = 1'b0; m_ready = 1'b1;
      repeat (6) @(posedge clk);
      #1;

      // ---------------- RATIO == 1 pipeline ----------------
      q.delete();
      got.delete();
      next_item = 1;
      for (int cyc = 0; cyc < 200 && got.size() < 5; cyc++) begin
         logic exp_v, exp_sr, in_acc, out_acc;
         w_s_valid = (next_item <= 5);
         w_s_data  = 16'(next_item);
         w_m_ready = $urandom_range(0, 1) == 1;
         exp_v  = (q.size() != 0);
         exp_sr = (q.size() == 0) || w_m_ready;
         @(negedge clk);
         check("r1_m_valid", 32'(w_m_valid), 32'(exp_v));
         check("r1_s_ready", 32'(w_s_ready), 32'(exp_sr));
         if (exp_v) check("r1_m_data", 32'(w_m_data), 32'(q[0].d));
         in_acc  = w_s_valid && exp_sr;
         out_acc = exp_v && w_m_ready;
         if (out_acc) got.push_back(w_m_data);
         @(posedge clk); #1;
         if (out_acc) void'(q.pop_front());
         if (in_acc) begin
            beat_t b;
            b.d = w_s_data;
            b.l = 1'b0;
            q.push_back(b);
            next_item++;
         end
      end
      w_s_valid = 1'b0;
      check("r1_beat_count", 32'(got.size()), 32'd5);
      foreach (got[i]) check($sformatf("r1_order%0d", i), 32'(got[i]), 32'(i + 1));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
